// File: rtl/fp32_iter_divider.sv
// Sequential FP32 divider: restoring mantissa division, one quotient bit per clock, start/busy/done handshake.
// Optional macro FP_DIV_RNE_EN: round-to-nearest-even via a guard iteration (default build truncates).
module fp32_iter_divider #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic [EXP_W+MAN_W:0]   a,
   input  logic [EXP_W+MAN_W:0]   b,
   output logic [EXP_W+MAN_W:0]   result,
   output logic                   busy,
   output logic                   done,
   output logic                   overflow,
   output logic                   underflow,
   output logic                   div_by_zero,
   output logic                   invalid
);
   localparam int W     = EXP_W + MAN_W + 1;
   localparam int MW    = MAN_W + 1;
   localparam int ESW   = EXP_W + 2;
`ifdef FP_DIV_RNE_EN
   localparam int QW    = MW + 2;
`else
   localparam int QW    = MW + 1;
`endif
   localparam int CW    = $clog2(QW);
   localparam logic signed [ESW-1:0] EXP_BIAS = ESW'((1 << (EXP_W-1)) - 1);
   localparam logic signed [ESW-1:0] EXP_TOP  = ESW'((1 << EXP_W) - 2);
   localparam logic signed [ESW-1:0] EXP_ONE  = ESW'(1);

   typedef enum logic [2:0] {S_IDLE, S_CHECK, S_DIVIDE, S_NORM, S_DONE} state_t;
   state_t state, state_nx;

   logic [W-1:0]            a_r, b_r;
   logic                    sign_r;
   logic signed [ESW-1:0]   exp_r;
   logic [MW:0]             rem;
   logic [MW-1:0]           dvs;
   logic [QW-1:0]           q;
   logic [CW-1:0]           cnt;

   logic [EXP_W-1:0] ea, eb;
   logic [MAN_W-1:0] fa, fb;
   logic             sign, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;

   assign ea     = a_r[W-2:MAN_W];
   assign eb     = b_r[W-2:MAN_W];
   assign fa     = a_r[MAN_W-1:0];
   assign fb     = b_r[MAN_W-1:0];
   assign sign   = a_r[W-1] ^ b_r[W-1];
   // exponent-0 operands are flushed to zero, so subnormal fractions are ignored
   assign a_zero = (ea == '0);
   assign b_zero = (eb == '0);
   assign a_inf  = (ea == '1) && (fa == '0);
   assign b_inf  = (eb == '1) && (fb == '0);
   assign a_nan  = (ea == '1) && (fa != '0);
   assign b_nan  = (eb == '1) && (fb != '0);

   logic         spec_hit, spec_inv, spec_dbz;
   logic [W-1:0] spec_res;

   always_comb begin
      spec_hit = 1'b1;
      spec_inv = 1'b0;
      spec_dbz = 1'b0;
      spec_res = '0;
      if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
         spec_res = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
         spec_inv = 1'b1;
      end else if (a_inf) begin
         spec_res = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      end else if (b_zero) begin
         spec_res = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
         spec_dbz = 1'b1;
      end else if (a_zero || b_inf) begin
         spec_res = {sign, {(W-1){1'b0}}};
      end else begin
         spec_hit = 1'b0;
      end
   end

   logic [MAN_W-1:0]      frac;
   logic signed [ESW-1:0] exp_n;
   logic                  ovf_n, unf_n;
   logic [W-1:0]          norm_res;
`ifdef FP_DIV_RNE_EN
   logic                  guard, sticky;
   logic [MAN_W:0]        frac_rnd;
`endif

   always_comb begin
      frac  = '0;
      exp_n = exp_r;
`ifdef FP_DIV_RNE_EN
      guard    = 1'b0;
      sticky   = 1'b0;
      if (q[QW-1]) begin
         frac   = q[QW-2:2];
         guard  = q[1];
         sticky = q[0] | (rem != '0);
      end else begin
         frac   = q[QW-3:1];
         guard  = q[0];
         sticky = (rem != '0);
         exp_n  = exp_r - EXP_ONE;
      end
      frac_rnd = {1'b0, frac} + (MAN_W+1)'(guard & (sticky | frac[0]));
      // carry-out leaves the fraction at zero and bumps the exponent
      if (frac_rnd[MAN_W])
         exp_n = exp_n + EXP_ONE;
      frac = frac_rnd[MAN_W-1:0];
`else
      if (q[QW-1]) begin
         frac = q[QW-2:1];
      end else begin
         frac  = q[QW-3:0];
         exp_n = exp_r - EXP_ONE;
      end
`endif
      ovf_n = (exp_n > EXP_TOP);
      unf_n = (exp_n < EXP_ONE);
      if (ovf_n)
         norm_res = {sign_r, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      else if (unf_n)
         norm_res = {sign_r, {(W-1){1'b0}}};
      else
         norm_res = {sign_r, exp_n[EXP_W-1:0], frac};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= S_IDLE;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:   if (start) state_nx = S_CHECK;
         S_CHECK:  state_nx = spec_hit ? S_DONE : S_DIVIDE;
         S_DIVIDE: if (cnt == '0) state_nx = S_NORM;
         S_NORM:   state_nx = S_DONE;
         S_DONE:   state_nx = S_IDLE;
         default:  state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_r         <= '0;
         b_r         <= '0;
         sign_r      <= 1'b0;
         exp_r       <= '0;
         rem         <= '0;
         dvs         <= '0;
         q           <= '0;
         cnt         <= '0;
         result      <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         overflow    <= 1'b0;
         underflow   <= 1'b0;
         div_by_zero <= 1'b0;
         invalid     <= 1'b0;
      end else begin
         done <= 1'b0;
         // busy spans the done pulse and drops with it; a same-cycle accept below re-raises it
         if (done)
            busy <= 1'b0;
         case (state)
            S_IDLE: if (start) begin
               a_r         <= a;
               b_r         <= b;
               busy        <= 1'b1;
               overflow    <= 1'b0;
               underflow   <= 1'b0;
               div_by_zero <= 1'b0;
               invalid     <= 1'b0;
            end
            S_CHECK: begin
               sign_r <= sign;
               exp_r  <= $signed({2'b00, ea}) - $signed({2'b00, eb}) + EXP_BIAS;
               rem    <= {2'b01, fa};
               dvs    <= {1'b1, fb};
               q      <= '0;
               cnt    <= CW'(QW - 1);
               if (spec_hit) begin
                  result      <= spec_res;
                  invalid     <= spec_inv;
                  div_by_zero <= spec_dbz;
               end
            end
            S_DIVIDE: begin
               if (rem >= {1'b0, dvs}) begin
                  rem <= (rem - {1'b0, dvs}) << 1;
                  q   <= {q[QW-2:0], 1'b1};
               end else begin
                  rem <= rem << 1;
                  q   <= {q[QW-2:0], 1'b0};
               end
               cnt <= cnt - 1'b1;
            end
            S_NORM: begin
               result    <= norm_res;
               overflow  <= ovf_n;
               underflow <= unf_n;
            end
            S_DONE:  done <= 1'b1;
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_fp32_iter_divider.sv
// Self-checking bench for fp32_iter_divider: directed vectors plus random operands against an integer-division model.
module tb_fp32_iter_divider;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic [31:0] result;
   logic        busy, done, overflow, underflow, div_by_zero, invalid;

   int tests = 0;
   int fails = 0;

`ifdef FP_DIV_RNE_EN
   localparam int          LAT   = 29;
   localparam logic [31:0] THIRD = 32'h3EAAAAAB;
`else
   localparam int          LAT   = 28;
   localparam logic [31:0] THIRD = 32'h3EAAAAAA;
`endif

   always #5 clk = ~clk;

   fp32_iter_divider dut (
      .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
      .result(result), .busy(busy), .done(done), .overflow(overflow),
      .underflow(underflow), .div_by_zero(div_by_zero), .invalid(invalid)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // returns {special, invalid, div_by_zero, overflow, underflow, result}
   function automatic logic [36:0] ref_div(input logic [31:0] x, input logic [31:0] y);
      int ex, ey, e;
      logic s;
      bit xz, yz, xi, yi, xn, yn, hi;
      longint unsigned num, den, qq, sig;
`ifdef FP_DIV_RNE_EN
      bit g, st;
      longint unsigned rm;
`endif
      ex = int'(x[30:23]);
      ey = int'(y[30:23]);
      s  = x[31] ^ y[31];
      xz = (ex == 0);
      yz = (ey == 0);
      xi = (ex == 255) && (x[22:0] == 0);
      yi = (ey == 255) && (y[22:0] == 0);
      xn = (ex == 255) && (x[22:0] != 0);
      yn = (ey == 255) && (y[22:0] != 0);
      if (xn || yn || (xz && yz) || (xi && yi)) return {1'b1, 4'b1000, 32'h7FC00000};
      if (xi) return {1'b1, 4'b0000, s, 8'hFF, 23'd0};
      if (yz) return {1'b1, 4'b0100, s, 8'hFF, 23'd0};
      if (xz || yi) return {1'b1, 4'b0000, s, 31'd0};
      num = 64'({1'b1, x[22:0]}) << 25;
      den = 64'({1'b1, y[22:0]});
      qq  = num / den;
      e   = ex - ey + 127;
      hi  = (qq >= (64'd1 << 25));
      if (hi) sig = qq >> 2;
      else begin
         sig = qq >> 1;
         e   = e - 1;
      end
`ifdef FP_DIV_RNE_EN
      rm = num % den;
      g  = hi ? qq[1] : qq[0];
      st = (rm != 0) || (hi && qq[0]);
      if (g && (st || sig[0])) sig = sig + 1;
      if (sig >= (64'd1 << 24)) begin
         sig = sig >> 1;
         e   = e + 1;
      end
`endif
      if (e > 254) return {1'b0, 4'b0010, s, 8'hFF, 23'd0};
      if (e < 1)   return {1'b0, 4'b0001, s, 31'd0};
      return {1'b0, 4'b0000, s, 8'(e), 23'(sig)};
   endfunction

   task automatic run_div(input logic [31:0] x, input logic [31:0] y, input logic [31:0] exp_res,
                          input logic [3:0] exp_flags, input bit special, input string tag);
      int cyc;
      bit got, busy_ok;
      @(negedge clk);
      a = x; b = y; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      cyc = 0; got = 0; busy_ok = 1;
      while (!got && cyc < 40) begin
         @(posedge clk);
         #1 cyc++;
         if (busy !== 1'b1) busy_ok = 0;
         if (done === 1'b1) got = 1;
      end
      check({tag, " latency"}, 32'(cyc), special ? 32'd2 : 32'(LAT));
      check({tag, " busy"}, {31'd0, busy_ok}, 32'd1);
      check({tag, " result"}, result, exp_res);
      check({tag, " flags"}, {28'd0, invalid, div_by_zero, overflow, underflow}, {28'd0, exp_flags});
      @(posedge clk);
      #1 check({tag, " done/busy drop"}, {30'd0, done, busy}, 32'd0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] x, y;
      logic [36:0] m;
      int cyc, ndone;
      bit got;

      #12;
      check("reset result", result, 32'd0);
      check("reset ctrl", {26'd0, busy, done, overflow, underflow, div_by_zero, invalid}, 32'd0);
      @(negedge clk) rst_n = 1'b1;

      run_div(32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, 0, "6/2");
      run_div(32'h3F800000, 32'h40400000, THIRD,        4'b0000, 0, "1/3");
      run_div(32'h3F800000, 32'h00000000, 32'h7F800000, 4'b0100, 1, "1/0");
      run_div(32'hBF800000, 32'h00000000, 32'hFF800000, 4'b0100, 1, "-1/0");
      run_div(32'h00000000, 32'h00000000, 32'h7FC00000, 4'b1000, 1, "0/0");
      run_div(32'h7F800000, 32'h7F800000, 32'h7FC00000, 4'b1000, 1, "inf/inf");
      run_div(32'h7FC00001, 32'h3F800000, 32'h7FC00000, 4'b1000, 1, "nan/1");
      run_div(32'hFF800000, 32'h40000000, 32'hFF800000, 4'b0000, 1, "-inf/2");
      run_div(32'h40000000, 32'hFF800000, 32'h80000000, 4'b0000, 1, "2/-inf");
      run_div(32'h00000001, 32'h3F800000, 32'h00000000, 4'b0000, 1, "denorm/1");
      run_div(32'h7F7FFFFF, 32'h3F000000, 32'h7F800000, 4'b0010, 0, "overflow");
      run_div(32'h00800000, 32'h40000000, 32'h00000000, 4'b0001, 0, "underflow");

      // a start while busy must not re-latch operands or queue a second operation
      @(negedge clk);
      a = 32'h3F800000; b = 32'h40400000; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      a = 32'h40C00000; b = 32'h40000000; start = 1'b1;
      @(negedge clk) start = 1'b0;
      cyc = 0; got = 0;
      while (!got && cyc < 40) begin
         @(posedge clk);
         #1 cyc++;
         if (done === 1'b1) got = 1;
      end
      check("busy-start done seen", {31'd0, got}, 32'd1);
      check("busy-start result", result, THIRD);
      ndone = 0;
      repeat (35) begin
         @(posedge clk);
         #1 if (done === 1'b1) ndone++;
      end
      check("busy-start no second op", 32'(ndone), 32'd0);

      // asynchronous reset in the middle of a divide
      @(negedge clk);
      a = 32'h40C00000; b = 32'h40000000; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (9) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      check("midreset ctrl", {30'd0, busy, done}, 32'd0);
      check("midreset result", result, 32'd0);
      @(negedge clk) rst_n = 1'b1;
      run_div(32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, 0, "after reset");

      for (int i = 0; i < 40; i++) begin
         x = $urandom;
         y = $urandom;
         if (i % 4 != 3) begin
            x[30:23] = 8'($urandom_range(90, 165));
            y[30:23] = 8'($urandom_range(90, 165));
         end
         m = ref_div(x, y);
         run_div(x, y, m[31:0], m[35:32], m[36], $sformatf("rand%0d", i));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
